pool: RTL and testbench
=======================

POOL -- requirements
Module: pool

Interface
REQ-001 Parameter ASZ, default 16: address width; memory is 2^ASZ bytes (64 KB).
REQ-002 Parameter DSZ, default 32: data width; fixed at 32 in this revision.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-005 op  input  3  opcode: 000 NOP, 001 R1, 010 R2, 011 R4, 100 W1, 101 W2, 110 W4, 111 reserved.
REQ-006 ai  input  ASZ  unit-scaled address: byte index (size 1), halfword index (size 2), word index (size 4).
REQ-007 vi  input  DSZ  write data; low 8/16/32 bits used for W1/W2/W4.
REQ-008 st  output  2  status: 0 IDLE, 1 READ, 2 WRITE, 3 ERR.
REQ-009 ok  output  1  one-cycle pulse: previous sampled op completed.
REQ-010 ao  output  ASZ  effective byte address of last sampled non-NOP op.
REQ-011 vo  output  DSZ  read data, zero-extended.

Function
REQ-012 Storage SHALL be byte-addressable, little-endian, as four 8-bit banks (bank = byte address[1:0]), enabling single-cycle aligned 32-bit access.
REQ-013 Effective byte address SHALL be ai for R1/W1, ai<<1 for R2/W2, ai<<2 for R4/W4, truncated to ASZ bits (wraps modulo 64 KB); all accesses are therefore naturally aligned.
REQ-014 One op SHALL be sampled per rising edge; no handshake, no back-pressure; a new op may be issued every cycle.
REQ-015 Write: on the sampling edge, the addressed 1/2/4 bytes SHALL take vi[7:0]/vi[15:0]/vi[31:0] (lowest byte at lowest address); other bytes unchanged; vo unchanged.
REQ-016 Read: on the sampling edge, vo SHALL register the addressed bytes, zero-extended to 32 bits; one-cycle latency (valid after that edge).
REQ-017 Read of an address written in the immediately preceding cycle SHALL return the new data.
REQ-018 After sampling a read: st=1, ok=1, ao=effective address; after a write: st=2, ok=1, ao=effective address.
REQ-019 After sampling NOP: st=0, ok=0; ao and vo hold.
REQ-020 After sampling reserved op 111: st=3, ok=0, ao=effective address computed as size 4; memory and vo unchanged.
REQ-021 st and ok SHALL reflect only the most recently sampled op (re-evaluated every cycle).
REQ-022 Unknown/X-free: outputs SHALL always be driven from registers.

Reset
REQ-023 While rst=0: st=0, ok=0, ao=0, vo=0, asynchronously; ops ignored and no memory write occurs.
REQ-024 Memory contents SHALL NOT be cleared by reset; data written before reset remains readable after.
REQ-025 Reset asserted in the same cycle as a write SHALL suppress that write.
REQ-026 First op SHALL be sampled on the first rising edge with rst=1.

Verification
REQ-027 W4 ai=0..3 with vi=0x64636261, 0x68676665, 0x6c6b6a69, 0x706f6e6d ("abcd...mnop"), then R4 ai=0..3 -> vo=same words in order, ok=1, st=1, ao=0,4,8,12.
REQ-028 After REQ-027 load: R1 ai=1 -> vo=0x00000062; R2 ai=1 -> vo=0x00006463, ao=2.
REQ-029 W1 ai=5 vi=0x000000FF then next cycle R4 ai=1 -> vo=0x6867FF65 (back-to-back read-after-write).
REQ-030 op=111 ai=0 after load -> st=3, ok=0, vo holds prior value; subsequent R4 ai=0 -> 0x64636261.
REQ-031 R4 ai=0x4000 -> ao=0x0000 (wrap), vo=0x64636261.
REQ-032 Drop rst mid-sequence concurrently with W4 ai=0 vi=0xDEADBEEF -> outputs 0 immediately; after release R4 ai=0 -> 0x64636261.

Source files
------------

// File: rtl/pool.sv
// ---------------------------------------------------------------------------
// pool -- 64 KB byte-addressable scratch memory with a one-op-per-cycle
// command port.
//
// The memory is split into four 8-bit banks selected by byte address [1:0].
// This lets an aligned word touch all four banks in a single cycle.
// Byte, halfword and word accesses all complete in one cycle.
// Results are registered, so every output comes straight from a flop.
//
// Ports
//   clk  : single clock; all state changes happen on its rising edge
//   rst  : asynchronous, active-low reset; clears outputs but not memory
//   op   : 000 NOP, 001 R1, 010 R2, 011 R4, 100 W1, 101 W2, 110 W4,
//          111 reserved
//   ai   : unit-scaled address (byte, halfword or word index)
//   vi   : write data; the low 8/16/32 bits are used
//   st   : status of the last sampled op: 0 IDLE, 1 READ, 2 WRITE, 3 ERR
//   ok   : high for one cycle after a read or write has been sampled
//   ao   : effective byte address of the last sampled non-NOP op
//   vo   : last read data, zero-extended
// ---------------------------------------------------------------------------
module pool #(
    parameter int ASZ = 16,
    parameter int DSZ = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2:0]     op,
    input  logic [ASZ-1:0] ai,
    input  logic [DSZ-1:0] vi,
    output logic [1:0]     st,
    output logic           ok,
    output logic [ASZ-1:0] ao,
    output logic [DSZ-1:0] vo
);

    localparam int DEPTH = 2 ** (ASZ - 2);

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_R1  = 3'b001,
        OP_R2  = 3'b010,
        OP_R4  = 3'b011,
        OP_W1  = 3'b100,
        OP_W2  = 3'b101,
        OP_W4  = 3'b110,
        OP_RSV = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_ERR   = 2'd3
    } st_t;

    op_t            op_c;
    logic [ASZ-1:0] ea;
    logic [1:0]     size;
    logic           is_rd;
    logic           is_wr;
    logic           is_rsv;
    logic [ASZ-3:0] row;

    logic [7:0]     mem [4][DEPTH];
    logic [7:0]     rd_byte [4];
    logic [7:0]     wdat [4];
    logic [3:0]     we;
    logic [DSZ-1:0] rd_val;

    st_t            st_q;
    st_t            st_next;
    logic           ok_next;
    logic [ASZ-1:0] ao_next;
    logic [DSZ-1:0] vo_next;

    assign op_c = op_t'(op);

    // Decode the opcode into an access size and scale the address.
    // The shift drops the high bits, which gives the modulo-64 KB wrap.
    // Reserved op 111 still reports an address, computed as a word access.
    always_comb begin
        ea     = ai;
        size   = 2'd0;
        is_rd  = 1'b0;
        is_wr  = 1'b0;
        is_rsv = 1'b0;
        case (op_c)
            OP_R1:  begin is_rd = 1'b1; end
            OP_R2:  begin is_rd = 1'b1; size = 2'd1; ea = ai << 1; end
            OP_R4:  begin is_rd = 1'b1; size = 2'd2; ea = ai << 2; end
            OP_W1:  begin is_wr = 1'b1; end
            OP_W2:  begin is_wr = 1'b1; size = 2'd1; ea = ai << 1; end
            OP_W4:  begin is_wr = 1'b1; size = 2'd2; ea = ai << 2; end
            OP_RSV: begin is_rsv = 1'b1; size = 2'd2; ea = ai << 2; end
            default: begin end
        endcase
    end

    assign row = ea[ASZ-1:2];

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            rd_byte[b] = mem[b][row];
        end
    end

    // Steer write data to the banks (little-endian).
    // rst is folded in so that a write arriving while reset is held is dropped.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            we[b]   = 1'b0;
            wdat[b] = vi[7:0];
            if (rst && is_wr) begin
                case (size)
                    2'd0: begin
                        we[b] = (ea[1:0] == 2'(b));
                    end
                    2'd1: begin
                        we[b]   = (ea[1] == b[1]);
                        wdat[b] = b[0] ? vi[15:8] : vi[7:0];
                    end
                    default: begin
                        we[b]   = 1'b1;
                        wdat[b] = vi[8*b +: 8];
                    end
                endcase
            end
        end
    end

    always_comb begin
        case (size)
            2'd0:    rd_val = DSZ'(rd_byte[ea[1:0]]);
            2'd1:    rd_val = ea[1] ? DSZ'({rd_byte[3], rd_byte[2]})
                                    : DSZ'({rd_byte[1], rd_byte[0]});
            default: rd_val = DSZ'({rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]});
        endcase
    end

    // Memory has no reset, so its contents survive rst.
    // A read issued right after a write sees the new data, because the write
    // has already landed by the edge that samples the read.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[b][row] <= wdat[b];
            end
        end
    end

    // Next-state logic. Status and ok are recomputed on every cycle.
    // ao and vo hold their values unless an op updates them.
    always_comb begin
        st_next = ST_IDLE;
        ok_next = 1'b0;
        ao_next = ao;
        vo_next = vo;
        if (is_rd) begin
            st_next = ST_READ;
            ok_next = 1'b1;
            ao_next = ea;
            vo_next = rd_val;
        end else if (is_wr) begin
            st_next = ST_WRITE;
            ok_next = 1'b1;
            ao_next = ea;
        end else if (is_rsv) begin
            st_next = ST_ERR;
            ao_next = ea;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q <= ST_IDLE;
            ok   <= 1'b0;
            ao   <= '0;
            vo   <= '0;
        end else begin
            st_q <= st_next;
            ok   <= ok_next;
            ao   <= ao_next;
            vo   <= vo_next;
        end
    end

    assign st = st_q;

endmodule

// File: tb/tb_pool.sv
// ---------------------------------------------------------------------------
// tb_pool -- directed and randomized test of pool.
//
// A byte-array reference model computes the expected outputs of each op.
// When an op is driven, its expected outputs are pushed onto a scoreboard
// queue. They are popped and compared after the edge that samples the op.
// Fixed known words are also checked directly as literal constants.
// ---------------------------------------------------------------------------
module tb_pool;

    logic        clk;
    logic        rst;
    logic [2:0]  op;
    logic [15:0] ai;
    logic [31:0] vi;
    logic [1:0]  st;
    logic        ok;
    logic [15:0] ao;
    logic [31:0] vo;

    typedef struct {
        logic [1:0]  st;
        logic        ok;
        logic [15:0] ao;
        logic [31:0] vo;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mdl_mem [int];
    logic [1:0]  m_st;
    logic        m_ok;
    logic [15:0] m_ao;
    logic [31:0] m_vo;

    int tests_run    = 0;
    int tests_failed = 0;

    pool #(.ASZ(16), .DSZ(32)) dut (
        .clk(clk),
        .rst(rst),
        .op(op),
        .ai(ai),
        .vi(vi),
        .st(st),
        .ok(ok),
        .ao(ao),
        .vo(vo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model for one sampled op. It updates the model state and
    // returns the outputs expected after the sampling edge.
    task automatic modelOp(input logic [2:0] o, input logic [15:0] a, input logic [31:0] v,
                           input string tag, output exp_t e);
        logic [15:0] ea;
        int          nb;
        logic [31:0] rd;
        ea = a;
        nb = 1;
        if (o == 3'b010 || o == 3'b101) begin
            ea = a << 1;
            nb = 2;
        end else if (o == 3'b011 || o == 3'b110 || o == 3'b111) begin
            ea = a << 2;
            nb = 4;
        end
        m_st = 2'd0;
        m_ok = 1'b0;
        case (o)
            3'b001, 3'b010, 3'b011: begin
                rd = 32'h0;
                for (int i = 0; i < nb; i++) begin
                    rd[8*i +: 8] = mdl_mem[int'(ea) + i];
                end
                m_st = 2'd1;
                m_ok = 1'b1;
                m_ao = ea;
                m_vo = rd;
            end
            3'b100, 3'b101, 3'b110: begin
                for (int i = 0; i < nb; i++) begin
                    mdl_mem[int'(ea) + i] = v[8*i +: 8];
                end
                m_st = 2'd2;
                m_ok = 1'b1;
                m_ao = ea;
            end
            3'b111: begin
                m_st = 2'd3;
                m_ao = ea;
            end
            default: begin end
        endcase
        e.st  = m_st;
        e.ok  = m_ok;
        e.ao  = m_ao;
        e.vo  = m_vo;
        e.tag = tag;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        checkValue({e.tag, ".st"}, 32'(st), 32'(e.st));
        checkValue({e.tag, ".ok"}, 32'(ok), 32'(e.ok));
        checkValue({e.tag, ".ao"}, 32'(ao), 32'(e.ao));
        checkValue({e.tag, ".vo"}, vo, e.vo);
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [15:0] a,
                                 input logic [31:0] v, input string tag);
        exp_t e;
        @(negedge clk);
        op = o;
        ai = a;
        vi = v;
        modelOp(o, a, v, tag, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [31:0] words [4];
        logic [2:0]  ro;
        logic [15:0] ra;
        words[0] = 32'h64636261;
        words[1] = 32'h68676665;
        words[2] = 32'h6c6b6a69;
        words[3] = 32'h706f6e6d;

        rst  = 1'b0;
        op   = 3'b000;
        ai   = 16'h0;
        vi   = 32'h0;
        m_st = 2'd0;
        m_ok = 1'b0;
        m_ao = 16'h0;
        m_vo = 32'h0;

        #2;
        checkValue("reset.st", 32'(st), 32'h0);
        checkValue("reset.ok", 32'(ok), 32'h0);
        checkValue("reset.ao", 32'(ao), 32'h0);
        checkValue("reset.vo", vo, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Load "abcd...mnop" and read it back.
        for (int i = 0; i < 4; i++) applyStimulus(3'b110, 16'(i), words[i], "load_w4");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b011, 16'(i), 32'h0, "read_r4");
            checkValue("known_r4", vo, words[i]);
            checkValue("known_ao", 32'(ao), 32'(4 * i));
        end

        applyStimulus(3'b001, 16'd1, 32'h0, "r1_ai1");
        checkValue("known_r1", vo, 32'h00000062);
        applyStimulus(3'b010, 16'd1, 32'h0, "r2_ai1");
        checkValue("known_r2", vo, 32'h00006463);
        checkValue("known_r2_ao", 32'(ao), 32'h2);

        // A read issued right after a write.
        applyStimulus(3'b100, 16'd5, 32'h000000FF, "w1_ai5");
        applyStimulus(3'b011, 16'd1, 32'h0, "raw_r4");
        checkValue("known_raw", vo, 32'h6867FF65);

        applyStimulus(3'b000, 16'h1234, 32'h0, "nop");
        applyStimulus(3'b111, 16'd0, 32'hFFFFFFFF, "reserved");
        checkValue("known_rsv_vo", vo, 32'h6867FF65);
        applyStimulus(3'b011, 16'd0, 32'h0, "after_rsv");
        checkValue("known_after_rsv", vo, 32'h64636261);

        applyStimulus(3'b011, 16'h4000, 32'h0, "wrap_r4");
        checkValue("known_wrap_ao", 32'(ao), 32'h0);
        checkValue("known_wrap_vo", vo, 32'h64636261);

        applyStimulus(3'b101, 16'hFFFF, 32'hA5A5C3C3, "w2_top");
        applyStimulus(3'b010, 16'hFFFF, 32'h0, "r2_top");
        checkValue("known_r2_top", vo, 32'h0000C3C3);

        // Randomized mix over a pre-initialized region (bytes 64..95).
        for (int i = 0; i < 8; i++) applyStimulus(3'b110, 16'(16 + i), $urandom, "init_rand");
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 6));
            case (ro)
                3'b001, 3'b100: ra = 16'(64 + $urandom_range(0, 31));
                3'b010, 3'b101: ra = 16'(32 + $urandom_range(0, 15));
                default:        ra = 16'(16 + $urandom_range(0, 7));
            endcase
            applyStimulus(ro, ra, $urandom, "rand");
        end

        // Reset asserted while a write is presented.
        @(negedge clk);
        op  = 3'b110;
        ai  = 16'h0;
        vi  = 32'hDEADBEEF;
        rst = 1'b0;
        m_st = 2'd0;
        m_ok = 1'b0;
        m_ao = 16'h0;
        m_vo = 32'h0;
        #1;
        checkValue("midrst.st", 32'(st), 32'h0);
        checkValue("midrst.ok", 32'(ok), 32'h0);
        checkValue("midrst.ao", 32'(ao), 32'h0);
        checkValue("midrst.vo", vo, 32'h0);
        @(posedge clk);
        #1;
        checkValue("midrst_edge.vo", vo, 32'h0);
        @(negedge clk);
        op  = 3'b000;
        rst = 1'b1;
        applyStimulus(3'b011, 16'd0, 32'h0, "post_rst");
        checkValue("known_post_rst", vo, 32'h64636261);

        checkValue("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
